// File: rtl/booth_mult_seq.sv
// +-----------------------------------------------------------------------------+
// | booth_mult_seq : sequential radix-4 Booth signed 32x32 multiplier.          |
// |   Low 32 product bits, signed-overflow flag, one-cycle ready pulse.         |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module booth_mult_seq #(
  parameter int ITER = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] m_q, m_d;
  logic [66:0] p_q, p_d;

  logic [2:0]  w_window;
  logic [33:0] w_m_ext;
  logic [33:0] w_m2_ext;
  logic [33:0] w_pp;
  logic [33:0] w_hi_sum;

  // Partial product selection; 34-bit width keeps -(-2^31) and 2M exact.
  always_comb begin
    w_window = p_q[2:0];
    w_m_ext  = {{2{m_q[31]}}, m_q};
    w_m2_ext = {w_m_ext[32:0], 1'b0};
    w_pp     = '0;
    unique case (w_window)
      3'b001, 3'b010: w_pp = w_m_ext;
      3'b011:         w_pp = w_m2_ext;
      3'b100:         w_pp = ~w_m2_ext + 34'd1;
      3'b101, 3'b110: w_pp = ~w_m_ext + 34'd1;
      default:        w_pp = '0;
    endcase
    w_hi_sum = p_q[66:33] + w_pp;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    m_d     = m_q;
    p_d     = p_q;

    unique case (state_q)
      RUN: begin
        p_d     = {{2{w_hi_sum[33]}}, w_hi_sum, p_q[32:2]};
        count_d = count_q + 4'd1;
        if (count_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start always wins, aborting whatever is in flight.
    if (ctrl_MULT) begin
      m_d     = data_operandA;
      p_d     = {34'd0, data_operandB, 1'b0};
      count_d = 4'd0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      m_q     <= 32'd0;
      p_q     <= 67'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      m_q     <= m_d;
      p_q     <= p_d;
    end
  end

  // Overflow when the high part is not a pure sign extension of the low word.
  assign data_result    = p_q[32:1];
  assign data_exception = (p_q[66:33] != {34{p_q[32]}});
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule

`default_nettype wire
